// File: rtl/sort_block_loader.sv
// Packs a byte stream into BLK_LEN-element blocks for the merge-sort stage.
// Two ping-pong buffers let one block fill while the other is held for the sorter.
module sort_block_loader #(
    parameter int                DATA_W  = 8,
    parameter int                BLK_LEN = 4,
    parameter logic [DATA_W-1:0] PAD_VAL = 8'hFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic                        blk_valid,
    input  logic                        blk_ready,
    output logic [DATA_W*BLK_LEN-1:0]   blk_data,
    output logic [$clog2(BLK_LEN):0]    blk_cnt
);

    localparam int IDX_W = $clog2(BLK_LEN);
    localparam int CNT_W = IDX_W + 1;

    logic [1:0][BLK_LEN-1:0][DATA_W-1:0] buf_q, buf_d;
    logic [1:0][CNT_W-1:0]               cnt_q, cnt_d;
    logic [1:0]                          full_q, full_d;
    logic                                wr_sel_q, wr_sel_d;
    logic                                rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;

    logic accept;
    logic drain;
    logic close;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        idx_d    = idx_q;

        accept = s_valid && !full_q[wr_sel_q];
        drain  = full_q[rd_sel_q] && blk_ready;
        close  = (idx_q == IDX_W'(BLK_LEN - 1)) || s_last;

        // A drained buffer is always full, a filling one never is, so the two
        // updates below can never touch the same buffer in one cycle.
        if (drain) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end

        if (accept) begin
            buf_d[wr_sel_q][idx_q] = s_data;
            if (close) begin
                for (int i = 0; i < BLK_LEN; i++) begin
                    if (IDX_W'(i) > idx_q) begin
                        buf_d[wr_sel_q][i] = PAD_VAL;
                    end
                end
                cnt_d[wr_sel_q]  = CNT_W'(idx_q) + CNT_W'(1);
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
                idx_d            = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        s_ready   = !full_q[wr_sel_q];
        blk_valid = full_q[rd_sel_q];
        blk_data  = buf_q[rd_sel_q];
        blk_cnt   = cnt_q[rd_sel_q];
    end

endmodule
